// File: rtl/beagleg_pkg.sv
// Shared types for the BeagleG record path: serializer FSM states, byte type,
// and the byte-index width helper.
package beagleg_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } ser_state_e;

  // Index counter wide enough to hold 0..n (n = bytes per record).
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/record_hold_reg.sv
// Single-slot holding register with ready/valid on both sides. Both the
// upstream ready and the downstream valid come straight from flops.
module record_hold_reg #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic full_p0;

  assign out_valid = full_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_p0  <= 1'b0;
      in_ready <= 1'b1;
    end else if (in_valid && in_ready) begin
      full_p0  <= 1'b1;
      in_ready <= 1'b0;
    end else if (out_valid && out_ready) begin
      full_p0  <= 1'b0;
      in_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready)
      out_data <= in_data;
  end

endmodule

// File: rtl/record_serializer.sv
// Wide record in, ready/valid byte stream out, double-buffered for gapless frames.
// Define RECORD_SERIALIZER_CHECKSUM_EN to append a two's-complement checksum byte.
module record_serializer
  import beagleg_pkg::*;
#(
  parameter int RECORD_SIZE_BYTES = 16,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RECORD_SIZE_BYTES*8-1:0] in_record,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [7:0]                     out_byte,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic [COUNT_WIDTH-1:0]         records_sent
);

  localparam int RW = RECORD_SIZE_BYTES * 8;
  localparam int IW = idx_width(RECORD_SIZE_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(RECORD_SIZE_BYTES - 1);

  ser_state_e    state;
  logic [IW-1:0] idx_p0;
  logic [RW-1:0] shift_p0;
  logic [RW-1:0] shift_nxt;
  logic [RW-1:0] hold_data;
  logic [RW-1:0] load_data;
  logic          hold_full;
  logic          xfer;
  logic          last_data;
  logic          frame_done;
  logic          can_load;
  logic          load_now;

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  byte_t sum_p0;

  function automatic byte_t csum_byte(input byte_t sum, input byte_t last);
    return byte_t'(8'd0 - (sum + last));
  endfunction
`endif

  assign xfer      = out_valid && out_ready;
  assign last_data = (state == SEND) && (idx_p0 == LAST_IDX);
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  assign frame_done = xfer && (state == CSUM);
`else
  assign frame_done = xfer && last_data;
`endif

  // A new frame starts when idle or on the closing byte transfer; a held
  // record takes priority, otherwise an incoming one bypasses the hold.
  assign can_load  = (state == IDLE) || frame_done;
  assign load_now  = can_load && (hold_full || in_valid);
  assign load_data = hold_full ? hold_data : in_record;
  assign shift_nxt = shift_p0 >> 8;
  assign busy      = hold_full || (state != IDLE);

  record_hold_reg #(
    .WIDTH (RW)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_record),
    .in_valid  (in_valid && !can_load),
    .in_ready  (in_ready),
    .out_data  (hold_data),
    .out_valid (hold_full),
    .out_ready (can_load)
  );

  // Stage p0: active record shift register and running sum
  always_ff @(posedge clk) begin
    if (load_now)
      shift_p0 <= load_data;
    else if (xfer && (state == SEND))
      shift_p0 <= shift_nxt;
  end

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (load_now)
      sum_p0 <= '0;
    else if (xfer && (state == SEND))
      sum_p0 <= sum_p0 + out_byte;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx_p0       <= '0;
      out_valid    <= 1'b0;
      out_byte     <= '0;
      records_sent <= '0;
    end else begin
      if (frame_done)
        records_sent <= records_sent + 1'b1;

      if (load_now) begin
        state     <= SEND;
        idx_p0    <= '0;
        out_valid <= 1'b1;
        out_byte  <= load_data[7:0];
      end else if (xfer) begin
        if (state == SEND && !last_data) begin
          idx_p0   <= idx_p0 + IW'(1);
          out_byte <= shift_nxt[7:0];
        end
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
        else if (state == SEND) begin
          state    <= CSUM;
          out_byte <= csum_byte(sum_p0, out_byte);
        end
`endif
        else begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_record_serializer.sv
// Self-checking bench for record_serializer: queue-based frame model plus
// directed vectors with literal expectations.
module tb_record_serializer;

  localparam int N  = 16;
  localparam int RW = N * 8;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] in_record = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [15:0]   records_sent;

  always #5 clk = ~clk;

  record_serializer #(
    .RECORD_SIZE_BYTES (N),
    .COUNT_WIDTH       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_record    (in_record),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .records_sent (records_sent)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: byte queue of accepted frames, records in flight, completed count.
  logic [7:0] q[$];
  logic [7:0] seen[$];
  int         inflight = 0;
  int         sent = 0;
  int         fbytes = 0;
  int         ov_cycles = 0;
  bit         stall_prev = 0;
  logic [7:0] prev_byte = '0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      inflight   = 0;
      sent       = 0;
      fbytes     = 0;
      stall_prev = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(inflight > 0));
      chk("in_ready", 32'(in_ready), 32'(inflight < 2));
      chk("busy", 32'(busy), 32'(inflight > 0));
      chk("records_sent", 32'(records_sent), 32'(sent & 16'hFFFF));
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_byte", 32'(out_byte), 32'(prev_byte));
      end
      if (out_valid) ov_cycles++;
      if (out_valid && out_ready) begin
        chk("queue_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) chk("out_byte", 32'(out_byte), 32'(q.pop_front()));
        seen.push_back(out_byte);
        fbytes++;
        if (fbytes == FRAME) begin
          fbytes = 0;
          inflight--;
          sent++;
        end
      end
      if (in_valid && in_ready) begin
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < N; k++) begin
          q.push_back(in_record[8*k +: 8]);
          s = s + in_record[8*k +: 8];
        end
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
        q.push_back(8'd0 - s);
`endif
        inflight++;
      end
      stall_prev = out_valid && !out_ready;
      prev_byte  = out_byte;
    end
  end

  function automatic logic [RW-1:0] mk_rec(input logic [7:0] base, input logic [7:0] step);
    logic [RW-1:0] r;
    for (int k = 0; k < N; k++) r[8*k +: 8] = base + step * 8'(k);
    return r;
  endfunction

  task automatic send_rec(input logic [RW-1:0] r);
    int   b;
    logic acc;
    b = 0;
    in_record = r;
    in_valid  = 1'b1;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      b++;
    end while (!acc && b < 300);
    in_valid = 1'b0;
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy && b < 600) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  bit done;
  logic [RW-1:0] ra, rb;

  initial begin
    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_records_sent", 32'(records_sent), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single record 0x0F0E...0100
    out_ready = 1'b1;
    seen.delete();
    send_rec(mk_rec(8'h00, 8'h01));
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_byte0", 32'(out_byte), 32'h00);
    wait_idle();
    chk("single_len", 32'(seen.size()), 32'(FRAME));
    for (int k = 0; k < N; k++) chk("single_byte", 32'(seen[k]), 32'(k));
    chk("single_sent", 32'(records_sent), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);

    // Three back-to-back records, no gaps
    ov_cycles = 0;
    send_rec(mk_rec(8'h10, 8'h01));
    send_rec(mk_rec(8'h40, 8'h03));
    send_rec(mk_rec(8'hF0, 8'h11));
    wait_idle();
    chk("b2b_valid_cycles", 32'(ov_cycles), 32'(3 * FRAME));
    chk("b2b_sent", 32'(records_sent), 32'd4);

    // Random output stalls
    done = 0;
    fork
      begin
        send_rec(mk_rec(8'h21, 8'h05));
        send_rec(mk_rec(8'h7A, 8'hFF));
        send_rec(mk_rec(8'h03, 8'h09));
        done = 1;
      end
      begin
        for (int c = 0; c < 1000 && !done; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    chk("stall_sent", 32'(records_sent), 32'd7);

    // Input transfer on the same edge as the last-byte transfer
    ra = mk_rec(8'h50, 8'h01);
    rb = mk_rec(8'hA0, 8'h01);
    send_rec(ra);
    repeat (FRAME - 1) begin
      @(posedge clk);
      #1;
    end
    send_rec(rb);
    chk("same_edge_valid", 32'(out_valid), 32'd1);
    chk("same_edge_byte0", 32'(out_byte), 32'hA0);
    chk("same_edge_hold_empty", 32'(in_ready), 32'd1);
    chk("same_edge_sent", 32'(records_sent), 32'd8);
    wait_idle();

    // Reset at byte 7 with a second record held
    send_rec(mk_rec(8'h60, 8'h01));
    send_rec(mk_rec(8'hC0, 8'h01));
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_byte7", 32'(out_byte), 32'h67);
    chk("pre_rst_hold_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_byte", 32'(out_byte), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sent", 32'(records_sent), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    chk("post_rst_sent", 32'(records_sent), 32'd0);
    seen.delete();
    send_rec(mk_rec(8'h33, 8'h02));
    wait_idle();
    chk("post_rst_len", 32'(seen.size()), 32'(FRAME));
    chk("post_rst_first", 32'(seen[0]), 32'h33);
    chk("post_rst_sent1", 32'(records_sent), 32'd1);

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
    seen.delete();
    send_rec(mk_rec(8'h01, 8'h00));
    wait_idle();
    chk("csum_ones", 32'(seen[N]), 32'hF0);
    seen.delete();
    send_rec(mk_rec(8'h00, 8'h00));
    wait_idle();
    chk("csum_zeros", 32'(seen[N]), 32'h00);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
